trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
//  Trap sequencer between the ID/EX stage and the CSR file. Accepts ecall/illegal/mret events from ID/EX,
//  issues single-cycle commit pulses (sys_call_en/excep_en/mret_en) to the CSR file and flushes the pipeline.
//  Then hands a redirect PC (mtvec or mepc, read back from the CSR file) to fetch with a valid/ready handshake.
//  Holds the pipeline stalled for the whole sequence.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles flush_o stays high after the redirect is accepted (DRAIN length), >=1
//  CNT_W         16  width of trap_cnt_o (used only with ORV_TRAP_COUNT_EN)
// PORTS
//  clk               in   1   clock, all state on posedge
//  rst               in   1   synchronous, active-high reset (asserted == RstEnable == 1'b1)
//  stall_i           in   1   pipeline stall; ID/EX instruction not valid this cycle
//  ecall_i           in   1   ID/EX holds ecall
//  illegal_i         in   1   ID/EX holds illegal instruction
//  mret_i            in   1   ID/EX holds mret
//  pc_idex_i         in   32  PC of ID/EX instruction (CSR file captures it into mepc on commit)
//  csr_mtvec_i       in   32  mtvec from the CSR file
//  csr_mepc_i        in   32  mepc from the CSR file
//  fetch_ready_i     in   1   fetch accepts redirect this cycle
//  sys_call_en_o     out  1   commit-pulse: ecall trap to the CSR file
//  excep_en_o        out  1   commit-pulse: illegal-instruction trap to the CSR file
//  mret_en_o         out  1   commit-pulse: mret to the CSR file
//  flush_o           out  1   kill IF/ID and ID/EX contents
//  stall_o           out  1   hold PC/pipeline registers
//  redirect_valid_o  out  1   redirect_pc_o valid
//  redirect_pc_o     out  32  new fetch PC
//  trap_cnt_o        out  CNT_W  taken traps+mrets (only with ORV_TRAP_COUNT_EN)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; redirect_pc_o=0; kind=NONE; trap_cnt_o=0. Reset in any state aborts to IDLE next cycle.
//  Event accept (IDLE only): ev = ~stall_i & (illegal_i|ecall_i|mret_i).
//    Priority illegal > ecall > mret. The winner latches into kind (EXC/ECALL/MRET). Losers are dropped.
//    Events in any non-IDLE state are ignored (instruction already flushed).
//  FSM (registered outputs, Moore):
//    IDLE     : all outputs 0. ev -> COMMIT.
//    COMMIT   : exactly one cycle. Exactly one of excep_en_o/sys_call_en_o/mret_en_o=1 per kind.
//               flush_o=1, stall_o=1. pc_idex_i must still hold the trapping PC (stall_o holds ID/EX). -> REDIRECT.
//    REDIRECT : stall_o=1, flush_o=1, redirect_valid_o=1.
//               redirect_pc_o = kind==MRET ? {csr_mepc_i[31:1],1'b0} : {csr_mtvec_i[31:2],2'b00}.
//               CSR values are sampled here, one cycle after commit, so they include the commit update.
//               redirect_pc_o stays stable while valid & ~ready. fetch_ready_i -> DRAIN (load drain count).
//    DRAIN    : flush_o=1, stall_o=0, redirect_valid_o=0. Lasts FLUSH_CYCLES cycles. -> IDLE.
//  Latency: event cycle N -> commit pulse N+1 -> redirect_valid N+2. With ready tied high: back in IDLE at N+3+FLUSH_CYCLES.
//  A commit pulse never lasts more than one cycle and never repeats within a sequence, even if REDIRECT waits.
//  Drain counter: $clog2(FLUSH_CYCLES+1) bits, counts down; no wrap.
//  Back-to-back: a new event is first eligible in the first IDLE cycle after DRAIN.
// CONFIGURATION
//  ORV_TRAP_COUNT_EN defined:
//    trap_cnt_o increments by 1 on every COMMIT cycle (all kinds). Wraps 2^CNT_W-1 -> 0. Cleared only by rst.
//  ORV_TRAP_COUNT_EN undefined:
//    counter logic is not built and trap_cnt_o is tied to '0. All other behaviour is identical.
// TESTING
//  1 ecall_i=1, pc_idex_i=32'h0000_2140, mtvec=32'h0000_0103, ready=1
//    -> sys_call_en_o pulse at N+1; redirect_pc_o=32'h0000_0100 at N+2; flush_o high N+1..N+2+FLUSH_CYCLES.
//  2 mret_i=1, mepc=32'h0000_2145, fetch_ready_i low 3 cycles
//    -> mret_en_o single pulse; redirect_valid_o held 4 cycles; redirect_pc_o=32'h0000_2144 stable throughout.
//  3 illegal_i=ecall_i=mret_i=1 in the same cycle -> only excep_en_o pulses; target = mtvec.
//  4 ecall_i=1 with stall_i=1 -> no response. Event held through stall_i falling -> sequence starts the cycle after the fall.
//  5 rst asserted during REDIRECT -> next cycle IDLE, all outputs 0, no further commit pulse.
//    Fresh ecall afterwards -> normal sequence.
//  6 ORV_TRAP_COUNT_EN, CNT_W=4: 17 ecall sequences -> trap_cnt_o=1 (wrap). Without macro -> trap_cnt_o=0 throughout.

Source files
------------

// File: rtl/trap_ctrl_if.sv
// Trap sequencer bus: ID/EX event inputs, CSR read-back, CSR commit pulses,
// pipeline flush/stall and the fetch redirect handshake.
interface trap_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             stall_i;
    logic             ecall_i;
    logic             illegal_i;
    logic             mret_i;
    logic [31:0]      pc_idex_i;
    logic [31:0]      csr_mtvec_i;
    logic [31:0]      csr_mepc_i;
    logic             fetch_ready_i;
    logic             sys_call_en_o;
    logic             excep_en_o;
    logic             mret_en_o;
    logic             flush_o;
    logic             stall_o;
    logic             redirect_valid_o;
    logic [31:0]      redirect_pc_o;
    logic [CNT_W-1:0] trap_cnt_o;

    // master: pipeline/CSR/fetch side driving the sequencer
    modport master (
        output stall_i, ecall_i, illegal_i, mret_i, pc_idex_i,
               csr_mtvec_i, csr_mepc_i, fetch_ready_i,
        input  sys_call_en_o, excep_en_o, mret_en_o, flush_o, stall_o,
               redirect_valid_o, redirect_pc_o, trap_cnt_o
    );

    modport slave (
        input  stall_i, ecall_i, illegal_i, mret_i, pc_idex_i,
               csr_mtvec_i, csr_mepc_i, fetch_ready_i,
        output sys_call_en_o, excep_en_o, mret_en_o, flush_o, stall_o,
               redirect_valid_o, redirect_pc_o, trap_cnt_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// Trap sequencer: ID/EX event -> CSR commit pulse -> fetch redirect -> pipeline drain.
// Optional trap counter on trap_cnt_o is built only when ORV_TRAP_COUNT_EN is defined.
module trap_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    trap_ctrl_if.slave  bus
);
    localparam int DW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT, DRAIN} state_t;
    typedef enum logic [1:0] {K_NONE, K_EXC, K_ECALL, K_MRET} kind_t;

    state_t      state;
    kind_t       kind;
    kind_t       ev_kind;
    logic        ev;
    logic [DW-1:0] drain_cnt;
    logic [31:0] target;
    logic [31:0] pc_q;
    logic        pc_held;
    logic        sys_call_en;
    logic        excep_en;
    logic        mret_en;
    logic        flush;
    logic        stall;
    logic        rd_valid;
    logic        unused_bits;

    always_comb begin
        ev      = ~bus.stall_i & (bus.illegal_i | bus.ecall_i | bus.mret_i);
        ev_kind = bus.illegal_i ? K_EXC : (bus.ecall_i ? K_ECALL : K_MRET);
        target  = (kind == K_MRET) ? {bus.csr_mepc_i[31:1], 1'b0}
                                   : {bus.csr_mtvec_i[31:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            kind        <= K_NONE;
            drain_cnt   <= '0;
            pc_q        <= '0;
            pc_held     <= 1'b0;
            sys_call_en <= 1'b0;
            excep_en    <= 1'b0;
            mret_en     <= 1'b0;
            flush       <= 1'b0;
            stall       <= 1'b0;
            rd_valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ev) begin
                        state       <= COMMIT;
                        kind        <= ev_kind;
                        excep_en    <= (ev_kind == K_EXC);
                        sys_call_en <= (ev_kind == K_ECALL);
                        mret_en     <= (ev_kind == K_MRET);
                        flush       <= 1'b1;
                        stall       <= 1'b1;
                    end
                end
                COMMIT: begin
                    state       <= REDIRECT;
                    excep_en    <= 1'b0;
                    sys_call_en <= 1'b0;
                    mret_en     <= 1'b0;
                    rd_valid    <= 1'b1;
                end
                REDIRECT: begin
                    // CSR read-back already reflects the commit; freeze it for a stalled fetch.
                    if (!pc_held) begin
                        pc_q    <= target;
                        pc_held <= 1'b1;
                    end
                    if (bus.fetch_ready_i) begin
                        state     <= DRAIN;
                        rd_valid  <= 1'b0;
                        stall     <= 1'b0;
                        pc_held   <= 1'b0;
                        drain_cnt <= DW'(FLUSH_CYCLES);
                    end
                end
                DRAIN: begin
                    if (drain_cnt <= DW'(1)) begin
                        state     <= IDLE;
                        kind      <= K_NONE;
                        flush     <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sys_call_en_o    = sys_call_en;
    assign bus.excep_en_o       = excep_en;
    assign bus.mret_en_o        = mret_en;
    assign bus.flush_o          = flush;
    assign bus.stall_o          = stall;
    assign bus.redirect_valid_o = rd_valid;
    assign bus.redirect_pc_o    = rd_valid ? (pc_held ? pc_q : target) : 32'h0;

`ifdef ORV_TRAP_COUNT_EN
    logic [CNT_W-1:0] trap_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            trap_cnt <= '0;
        else if (state == COMMIT)
            trap_cnt <= trap_cnt + CNT_W'(1);
    end

    assign bus.trap_cnt_o = trap_cnt;
`else
    assign bus.trap_cnt_o = {CNT_W{1'b0}};
`endif

    // mepc capture of pc_idex_i happens in the CSR file; the low target bits are forced
    assign unused_bits = ^{bus.pc_idex_i, bus.csr_mtvec_i[1:0], bus.csr_mepc_i[0]};
endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized bench for trap_ctrl; expected outputs come from a per-sequence timeline model.
module tb_trap_ctrl;
    localparam int FC = 2;
    localparam int CW = 4;
`ifdef ORV_TRAP_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trap_ctrl_if #(.CNT_W(CW)) bus ();

    trap_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Timeline model: one sequence = event n, commit n+1, redirect n+2..n+2+w, drain FC cycles
    int          cyc       = 0;
    int          idle_from = 0;
    int          seq_n     = -100;
    int          seq_w     = 0;
    int          seq_kind  = 0;
    bit          have_seq  = 1'b0;
    int          num_seq   = 0;
    logic [31:0] seq_tgt   = '0;
    logic [31:0] pc_r      = '0;
    logic [31:0] mtvec_r   = '0;
    logic [31:0] mepc_r    = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    endtask

    task automatic step(input bit r, input bit st, input bit ec, input bit il, input bit mr,
                        input logic [31:0] pc, input logic [31:0] mtvec,
                        input logic [31:0] mepc, input int w);
        int d;
        bit busy;
        bit e_sc, e_ex, e_mr, e_fl, e_st, e_v;
        logic [31:0] e_pc, e_cnt;
        @(posedge clk);
        #1;
        busy = (cyc < idle_from);
        d    = cyc - seq_n;
        if (!busy) begin
            pc_r    = pc;
            mtvec_r = mtvec;
            mepc_r  = mepc;
        end
        rst               = r;
        bus.stall_i       = st;
        bus.ecall_i       = ec;
        bus.illegal_i     = il;
        bus.mret_i        = mr;
        bus.pc_idex_i     = pc_r;
        bus.csr_mtvec_i   = mtvec_r;
        bus.csr_mepc_i    = mepc_r;
        if (busy && have_seq && d >= 2 && d <= 2 + seq_w)
            bus.fetch_ready_i = (d == 2 + seq_w);
        else
            bus.fetch_ready_i = 1'($urandom_range(0, 1));

        {e_sc, e_ex, e_mr, e_fl, e_st, e_v} = '0;
        e_pc = '0;
        if (busy && have_seq) begin
            if (d == 1) begin
                e_fl = 1'b1;
                e_st = 1'b1;
                e_ex = (seq_kind == 0);
                e_sc = (seq_kind == 1);
                e_mr = (seq_kind == 2);
            end else if (d <= 2 + seq_w) begin
                e_fl = 1'b1;
                e_st = 1'b1;
                e_v  = 1'b1;
                e_pc = seq_tgt;
            end else begin
                e_fl = 1'b1;
            end
        end
        e_cnt = CNT_ON ? 32'((num_seq - ((have_seq && cyc <= seq_n + 1) ? 1 : 0)) & ((1 << CW) - 1))
                       : 32'h0;

        #1;
        chk("sys_call_en", 32'(bus.sys_call_en_o), 32'(e_sc));
        chk("excep_en", 32'(bus.excep_en_o), 32'(e_ex));
        chk("mret_en", 32'(bus.mret_en_o), 32'(e_mr));
        chk("flush", 32'(bus.flush_o), 32'(e_fl));
        chk("stall", 32'(bus.stall_o), 32'(e_st));
        chk("redirect_valid", 32'(bus.redirect_valid_o), 32'(e_v));
        chk("redirect_pc", bus.redirect_pc_o, e_pc);
        chk("trap_cnt", 32'(bus.trap_cnt_o), e_cnt);

        if (r) begin
            idle_from = cyc + 1;
            have_seq  = 1'b0;
            num_seq   = 0;
        end else if (!busy && !st && (ec || il || mr)) begin
            seq_n     = cyc;
            seq_w     = w;
            have_seq  = 1'b1;
            seq_kind  = il ? 0 : (ec ? 1 : 2);
            seq_tgt   = (seq_kind == 2) ? {mepc_r[31:1], 1'b0} : {mtvec_r[31:2], 2'b00};
            idle_from = cyc + 3 + w + FC;
            num_seq++;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, pc_r, mtvec_r, mepc_r, 0);
    endtask

    initial begin
        bus.stall_i = 0; bus.ecall_i = 0; bus.illegal_i = 0; bus.mret_i = 0;
        bus.pc_idex_i = 0; bus.csr_mtvec_i = 0; bus.csr_mepc_i = 0; bus.fetch_ready_i = 0;
        repeat (2) @(posedge clk);

        idle(2);
        // ecall, mtvec low bits masked, ready immediately
        step(0, 0, 1, 0, 0, 32'h0000_2140, 32'h0000_0103, 32'h0000_0000, 0);
        idle(7);
        // mret with fetch holding off three cycles
        step(0, 0, 0, 0, 1, 32'h0000_3000, 32'h0000_0103, 32'h0000_2145, 3);
        idle(10);
        // all three at once: illegal wins
        step(0, 0, 1, 1, 1, 32'h0000_4000, 32'h0000_0200, 32'h0000_5555, 1);
        idle(8);
        // event under stall, held across the stall fall
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 32'h0000_4444, 32'h0000_0300, 32'h0, 0);
        step(0, 0, 1, 0, 0, 32'h0000_4444, 32'h0000_0300, 32'h0, 0);
        idle(7);
        // reset while REDIRECT waits, then a fresh ecall
        step(0, 0, 1, 0, 0, 32'h0000_6000, 32'h0000_0400, 32'h0, 3);
        idle(2);
        step(1, 0, 0, 0, 0, pc_r, mtvec_r, mepc_r, 0);
        idle(4);
        step(0, 0, 1, 0, 0, 32'h0000_6004, 32'h0000_0404, 32'h0, 0);
        idle(7);
        // counter wrap: 17 back-to-back ecall sequences after reset
        step(1, 0, 0, 0, 0, pc_r, mtvec_r, mepc_r, 0);
        for (int i = 0; i < 17 * (3 + FC); i++)
            step(0, 0, 1, 0, 0, 32'h0000_7000, 32'h0000_0500, 32'h0, 0);
        idle(6);
        chk("wrap_cnt", 32'(bus.trap_cnt_o), CNT_ON ? 32'd1 : 32'd0);

        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 3) == 0),
                 $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
